// File: rtl/sccb_arbiter.sv
// sccb_arbiter: round-robin sharing of one SCCB/I2C write engine between
// several register-write requesters. Frames each 24-bit write with the
// device address, retries on NACK, times out a stuck engine, and reports a
// one-cycle done/err pulse back to the requester that owned the engine.
module sccb_arbiter #(
  parameter int         NUM_REQ     = 3,
  parameter logic [7:0] DEV_ADDR    = 8'h78,
  parameter int         MAX_RETRY   = 2,
  parameter int         TIMEOUT_CYC = 1023
) (
  input  logic                   clock_20k,
  input  logic                   camera_rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [24*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic                   busy,
  output logic [31:0]            i2c_data,
  output logic                   start,
  input  logic                   tr_end,
  input  logic                   ack
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TOUT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    CHECK   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_nxt;
  logic [IDX_W-1:0]     owner, owner_nxt;
  logic [RETRY_W-1:0]   retry_cnt, retry_nxt;
  logic [TOUT_W-1:0]    tout_cnt, tout_nxt, tout_inc;
  logic [NUM_REQ-1:0]   grant_nxt, done_nxt, err_nxt, owner_hot;
  logic                 start_nxt, busy_nxt;
  logic [31:0]          data_nxt;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  int                   cand;

  assign owner_hot = NUM_REQ'(1) << owner;
  assign tout_inc  = tout_cnt + TOUT_W'(1);

  // Pick the first pending requester at or above the RR pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    retry_nxt = retry_cnt;
    tout_nxt  = tout_cnt;
    grant_nxt = grant;
    done_nxt  = '0;
    err_nxt   = '0;
    start_nxt = start;
    data_nxt  = i2c_data;

    unique case (state)
      IDLE: begin
        if (win_found) begin
          data_nxt  = {DEV_ADDR, req_data[24*int'(win_idx) +: 24]};
          owner_nxt = win_idx;
          grant_nxt = NUM_REQ'(1) << win_idx;
          start_nxt = 1'b1;
          retry_nxt = '0;
          tout_nxt  = '0;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        tout_nxt = tout_inc;
        if (tr_end) begin
          start_nxt = 1'b0;
          state_nxt = CHECK;
        end else if (tout_inc == TOUT_W'(TIMEOUT_CYC)) begin
          start_nxt = 1'b0;
          err_nxt   = owner_hot;
          state_nxt = RELEASE;
        end
      end
      CHECK: begin
        if (!ack) begin
          done_nxt  = owner_hot;
          state_nxt = RELEASE;
        end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
          retry_nxt = retry_cnt + RETRY_W'(1);
          tout_nxt  = '0;
          start_nxt = 1'b1;
          state_nxt = ACTIVE;
        end else begin
          err_nxt   = owner_hot;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        grant_nxt = '0;
        rr_nxt    = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock_20k) begin
    if (camera_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      retry_cnt <= '0;
      tout_cnt  <= '0;
      grant     <= '0;
      done      <= '0;
      err       <= '0;
      busy      <= 1'b0;
      start     <= 1'b0;
      i2c_data  <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner     <= owner_nxt;
      retry_cnt <= retry_nxt;
      tout_cnt  <= tout_nxt;
      grant     <= grant_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      busy      <= busy_nxt;
      start     <= start_nxt;
      i2c_data  <= data_nxt;
    end
  end

endmodule

// File: doc/sccb_arbiter.md
# sccb_arbiter

Shares the single SCCB/I2C write engine (`i2c_com`) between several register-write requesters, such as the boot-time register sequencer, a runtime exposure/AE writer and a mode-switch writer. It runs in the 20 kHz I2C control domain and sits between the requesters and the engine. It performs round-robin arbitration, frames each 24-bit register write with the device address, retries on NACK, and reports per-requester completion or error.

## Interface
- `NUM_REQ`, default 3: number of requesters (2..8).
- `DEV_ADDR`, default 8'h78: 8-bit SCCB write address prepended to every transfer.
- `MAX_RETRY`, default 2: extra attempts after a NACK before an error is reported.
- `TIMEOUT_CYC`, default 1023: maximum `clock_20k` cycles per attempt awaiting `tr_end`.
- `clock_20k` in, 1: I2C control clock; the only clock.
- `camera_rst` in, 1: reset, synchronous, active-high.
- `req` in, NUM_REQ: per-requester level request.
- `req_data` in, 24*NUM_REQ: per-requester {reg_addr[15:0], value[7:0]}; slice i is `[24*i+23:24*i]`.
- `grant` out, NUM_REQ: one-hot; the requester currently owning the engine.
- `done` out, NUM_REQ: one-cycle pulse; write ACKed.
- `err` out, NUM_REQ: one-cycle pulse; write failed (NACK after retries, or timeout).
- `busy` out, 1: high in every state except IDLE.
- `i2c_data` out, 32: {DEV_ADDR, req_data[winner]} to the engine.
- `start` out, 1: engine start, held high until `tr_end`.
- `tr_end` in, 1: engine transfer finished (level, stays high until `start` falls).
- `ack` in, 1: engine acknowledge status, valid while `tr_end` is high; 1 = NACK, 0 = ACK.

## Operation
- Reset values: all outputs 0 (`i2c_data` = 0). State is IDLE, RR pointer is 0, retry and timeout counters are 0.
- Finite state machine (FSM): IDLE → ACTIVE → CHECK → (ACTIVE on retry | RELEASE) → IDLE.
- **IDLE**:
  - If `req` is nonzero, the winner is the first set bit searching upward from the RR pointer, wrapping modulo NUM_REQ.
  - Register `i2c_data` = {DEV_ADDR, winner slice}, set `grant[w]`=1 and `start`=1, clear the retry and timeout counters, and go to ACTIVE.
  - `req_data` is sampled only here; later changes are ignored until the next grant.
- **ACTIVE**:
  - The timeout counter increments each cycle.
  - On `tr_end`=1: `start`<=0, go to CHECK.
  - Otherwise, if the counter reaches TIMEOUT_CYC: `start`<=0, `err[w]`<=1, go to RELEASE. No retry on timeout.
- **CHECK**: `start` is low for this cycle; `ack` is sampled.
  - `ack`=0: `done[w]`<=1, go to RELEASE.
  - `ack`=1 and retry count < MAX_RETRY: increment the retry count, clear the timeout counter, `start`<=1 with the same `i2c_data`, go to ACTIVE.
  - `ack`=1 and retries exhausted: `err[w]`<=1, go to RELEASE.
- **RELEASE**:
  - The `done`/`err` pulse is visible during this cycle only.
  - `grant`<=0, RR pointer <= (w+1) mod NUM_REQ, go to IDLE.
- Exactly one of `done`/`err` fires per grant. `grant` is never multi-hot.
- Requester rule:
  - Hold `req` and `req_data` stable from raising `req` until its `done`/`err`.
  - In the cycle after the pulse, either drop `req`, or keep it high with new data as a fresh request.
  - A fresh request competes normally; the RR pointer has already moved past it.
- Simultaneous requests are resolved only by the RR pointer; there are no fixed priorities.
- `req` bits dropping while not granted are simply not served. Dropping `req` while granted does not abort the transfer.
- `start` is low for at least one cycle between any two attempts, including retries, so the engine re-arms.
- Reset asserted mid-transfer returns all state to reset values on the next edge; `start` drops immediately and no `done`/`err` is emitted.

## Timing
- Request latency: `req` rising while IDLE gives `grant` and `start` high on the next edge (1 cycle).
- Completion: the first `tr_end`=1 cycle is T. CHECK is at T+1, RELEASE with the pulse is at T+2, and IDLE is at T+3.
- Back-to-back arbitration: the next transfer's `start` rises at T+4 at the earliest. The turnaround from `tr_end` to the next `start` is 4 cycles.
- Each retry adds one CHECK cycle with `start` low, followed by a full engine transfer.
- Timeout: `err` is at the cycle after TIMEOUT_CYC cycles in ACTIVE without `tr_end`.
- `busy` = (state != IDLE), registered.

## Test plan
- **Single write:**
  - Stimulus: `req`[1]=1 with data 24'h300882, engine model returning `tr_end` after 40 cycles with `ack`=0.
  - Required response: `i2c_data`=32'h78300882 with `start` high 1 cycle after `req`, `done`[1] pulse at T+2, `grant` low at T+3.
- **Round-robin:**
  - Stimulus: `req`=3'b111 held continuously, with each requester re-requesting after its pulse.
  - Required response: grant order 0,1,2,0,1,2. No requester is granted twice consecutively while others wait.
- **NACK retry:**
  - Stimulus: engine returns `ack`=1 on every attempt, with MAX_RETRY=2.
  - Required response: exactly 3 `start` pulses each separated by ≥1 low cycle, then a single `err[w]`, and no `done`.
- **NACK then ACK:**
  - Stimulus: `ack`=1 on the first attempt, 0 on the second.
  - Required response: 2 attempts with identical `i2c_data`, then `done[w]`, and no `err`.
- **Timeout:**
  - Stimulus: the engine never asserts `tr_end`, with TIMEOUT_CYC=16.
  - Required response: `start` falls after 16 ACTIVE cycles, `err[w]` pulses, and the next requester is granted afterwards.
- **Reset mid-transfer:**
  - Stimulus: assert `camera_rst` for 1 cycle while ACTIVE.
  - Required response: `start`, `grant`, `busy` = 0 on the next edge. No `done`/`err`. RR pointer is 0, so the next grant goes to the lowest pending requester.
